// File: rtl/mode1_max_reduce.sv
// Streaming max-reduction over 4-lane fp beats: a 3-stage compare pipeline feeds a
// running-max register, and the final max is presented on a valid/ready output.
module mode1_max_reduce #(
  parameter int LEN_W     = 8,
  parameter int EXPONENT  = 5,
  parameter int MANTISSA  = 10,
  parameter int DATAWIDTH = EXPONENT + MANTISSA + 1,
  parameter logic [DATAWIDTH-1:0] NEG_INF = 16'hFC00
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic [LEN_W-1:0]     vec_len,
  input  logic                 inp_valid,
  output logic                 inp_ready,
  input  logic [DATAWIDTH-1:0] a_inp0,
  input  logic [DATAWIDTH-1:0] a_inp1,
  input  logic [DATAWIDTH-1:0] a_inp2,
  input  logic [DATAWIDTH-1:0] a_inp3,
  output logic [DATAWIDTH-1:0] max_outp,
  output logic                 max_valid,
  input  logic                 max_ready
);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} state_t;

  // Sign-magnitude "a > b" for non-NaN values; +0 and -0 compare equal.
  function automatic logic fp_agtb(input logic [DATAWIDTH-1:0] a, input logic [DATAWIDTH-1:0] b);
    logic [DATAWIDTH-2:0] mag_a;
    logic [DATAWIDTH-2:0] mag_b;
    mag_a = a[DATAWIDTH-2:0];
    mag_b = b[DATAWIDTH-2:0];
    if (mag_a == '0 && mag_b == '0) return 1'b0;
    if (a[DATAWIDTH-1] != b[DATAWIDTH-1]) return b[DATAWIDTH-1];
    if (!a[DATAWIDTH-1]) return mag_a > mag_b;
    return mag_a < mag_b;
  endfunction

  state_t               state_reg;
  logic [LEN_W-1:0]     cnt_reg;
  logic                 inp_ready_reg;
  logic                 max_valid_reg;
  logic [DATAWIDTH-1:0] max_outp_reg;
  logic [DATAWIDTH-1:0] run_max_reg;
  logic                 s1_valid_reg;
  logic                 s2_valid_reg;
  logic [DATAWIDTH-1:0] s1_max_reg [2];
  logic [DATAWIDTH-1:0] s2_max_reg;
  logic [DATAWIDTH-1:0] lanes [4];
  logic                 accept;

  assign lanes[0] = a_inp0;
  assign lanes[1] = a_inp1;
  assign lanes[2] = a_inp2;
  assign lanes[3] = a_inp3;
  assign accept   = inp_valid & inp_ready_reg;

  assign inp_ready = inp_ready_reg;
  assign max_valid = max_valid_reg;
  assign max_outp  = max_outp_reg;

  // S1: pairwise max; a tie keeps the lower-index lane.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_pair
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          s1_max_reg[gi] <= NEG_INF;
        end else if (accept) begin
          s1_max_reg[gi] <= fp_agtb(lanes[2*gi+1], lanes[2*gi]) ? lanes[2*gi+1] : lanes[2*gi];
        end
      end
    end
  endgenerate

  // S2: beat max
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s2_max_reg <= NEG_INF;
    end else if (s1_valid_reg) begin
      s2_max_reg <= fp_agtb(s1_max_reg[1], s1_max_reg[0]) ? s1_max_reg[1] : s1_max_reg[0];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      inp_ready_reg <= 1'b0;
      max_valid_reg <= 1'b0;
      max_outp_reg  <= NEG_INF;
      run_max_reg   <= NEG_INF;
      s1_valid_reg  <= 1'b0;
      s2_valid_reg  <= 1'b0;
    end else begin
      s1_valid_reg <= accept;
      s2_valid_reg <= s1_valid_reg;
      // S3: the running max only moves on a strictly greater beat max.
      if (s2_valid_reg && fp_agtb(s2_max_reg, run_max_reg)) begin
        run_max_reg <= s2_max_reg;
      end
      case (state_reg)
        IDLE: begin
          if (start) begin
            if (vec_len != '0) begin
              state_reg     <= ACCUM;
              run_max_reg   <= NEG_INF;
              cnt_reg       <= vec_len;
              inp_ready_reg <= 1'b1;
            end else begin
              state_reg     <= HOLD;
              max_outp_reg  <= NEG_INF;
              max_valid_reg <= 1'b1;
            end
          end
        end
        ACCUM: begin
          if (accept) begin
            cnt_reg <= cnt_reg - LEN_W'(1);
            if (cnt_reg == LEN_W'(1)) begin
              state_reg     <= DRAIN;
              inp_ready_reg <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (!s1_valid_reg && !s2_valid_reg) begin
            state_reg     <= HOLD;
            max_outp_reg  <= run_max_reg;
            max_valid_reg <= 1'b1;
          end
        end
        HOLD: begin
          if (max_ready) begin
            state_reg     <= IDLE;
            max_valid_reg <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
